// File: rtl/iq_int_alu.sv
// ---------------------------------------------------------------------------
// iq_int_alu : integer issue queue in front of the ALU execution unit.
//
// Holds renamed micro-ops from dispatch until both sources are ready, then
// issues the oldest ready op to the ALU through a registered issue stage.
// Storage is a collapsing queue: index 0 is the oldest entry and valid
// entries are always contiguous from index 0.
//
// Ports
//   Clk, Rest             clock, synchronous active-low reset
//   IqFlash               flush: empties the queue and the issue register
//   Disp*                 dispatch side (one micro-op per cycle)
//   IqFull                registered, high when all DEPTH entries are used
//   WakeAble/Addr/Date    five writeback/bypass broadcasts
//                         {Csr,Mul,Alu2,Bru,Alu}, slot 0 = Alu
//   AluReq                ALU can take an op this cycle
//   Alu*                  registered issued op (all zero = nop)
//
// Handshakes
//   Dispatch: an op is taken at a posedge when DispAble=1, IqFull=0 and
//   IqFlash=0; otherwise DispAble is ignored (nothing is back-pressured
//   beyond IqFull). Issue: AluReq=1 is the ALU's ready; when an entry is
//   ready the Alu* outputs carry it for exactly one cycle after the posedge,
//   and carry all zeros (MicOp 0 = nop) in every other cycle.
// ---------------------------------------------------------------------------
module iq_int_alu #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 4,
  parameter int MOPW  = 8
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             IqFlash,
  input  logic             DispAble,
  input  logic [31:0]      DispPc,
  input  logic [MOPW-1:0]  DispMicOp,
  input  logic             DispSrc1Able,
  input  logic [6:0]       DispSrc1Addr,
  input  logic             DispSrc1Ready,
  input  logic [31:0]      DispSrc1Date,
  input  logic             DispSrc2Able,
  input  logic [6:0]       DispSrc2Addr,
  input  logic             DispSrc2Ready,
  input  logic [31:0]      DispSrc2Date,
  input  logic [19:0]      DispImm,
  input  logic             DispRdAble,
  input  logic [6:0]       DispRdAddr,
  input  logic [5:0]       DispROBPtr,
  output logic             IqFull,
  input  logic [4:0]       WakeAble,
  input  logic [34:0]      WakeAddr,
  input  logic [159:0]     WakeDate,
  input  logic             AluReq,
  output logic [31:0]      AluInstPc,
  output logic [MOPW-1:0]  AluMicOperate,
  output logic             AluSrc1Able,
  output logic [6:0]       AluSrc1Addr,
  output logic [31:0]      AluSrc1Date,
  output logic             AluSrc2Able,
  output logic [6:0]       AluSrc2Addr,
  output logic [31:0]      AluSrc2Date,
  output logic [19:0]      AluImmDate,
  output logic             AluRdAble,
  output logic [6:0]       AluRdAddr,
  output logic [5:0]       AluROBPtr
);

  localparam int NWAKE = 5;

  // Payload of one entry: exactly the fields that leave on the issue port.
  // Per-source ready bits are kept in separate vectors below.
  typedef struct packed {
    logic [31:0]     pc;
    logic [MOPW-1:0] mop;
    logic            s1_able;
    logic [6:0]      s1_tag;
    logic [31:0]     s1_data;
    logic            s2_able;
    logic [6:0]      s2_tag;
    logic [31:0]     s2_data;
    logic [19:0]     imm;
    logic            rd_able;
    logic [6:0]      rd_tag;
    logic [5:0]      rob;
  } uop_t;

  // Queue state
  uop_t             ent_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rdy1_q;
  logic [DEPTH-1:0] rdy2_q;
  logic [CNTW-1:0]  count;
  uop_t             iss_q;

  // Wakeup result for one source: returns {ready, data}. The loop runs from
  // the highest slot down so that the lowest matching slot is applied last
  // and therefore wins when several broadcasts carry the same tag.
  function automatic logic [32:0] wake_src(
    input logic         src_able,
    input logic         src_ready,
    input logic [6:0]   src_tag,
    input logic [31:0]  src_data,
    input logic [4:0]   w_able,
    input logic [34:0]  w_tag,
    input logic [159:0] w_data
  );
    logic [32:0] r;
    r = {src_ready, src_data};
    if (src_able && !src_ready) begin
      for (int i = NWAKE - 1; i >= 0; i--) begin
        if (w_able[i] && (w_tag[7*i +: 7] == src_tag)) begin
          r = {1'b1, w_data[32*i +: 32]};
        end
      end
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Wakeup: stored entries and the incoming dispatch op both see this
  // cycle's broadcasts. The results only become visible to select after the
  // next posedge, so a woken entry issues one cycle later at the earliest.
  // -------------------------------------------------------------------------
  uop_t             ent_w [DEPTH];
  logic [DEPTH-1:0] rdy1_w;
  logic [DEPTH-1:0] rdy2_w;
  uop_t             disp_op;
  logic             disp_r1;
  logic             disp_r2;

  always_comb begin
    rdy1_w = '0;
    rdy2_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_w[k] = ent_q[k];
      {rdy1_w[k], ent_w[k].s1_data} = wake_src(ent_q[k].s1_able, rdy1_q[k],
        ent_q[k].s1_tag, ent_q[k].s1_data, WakeAble, WakeAddr, WakeDate);
      {rdy2_w[k], ent_w[k].s2_data} = wake_src(ent_q[k].s2_able, rdy2_q[k],
        ent_q[k].s2_tag, ent_q[k].s2_data, WakeAble, WakeAddr, WakeDate);
    end

    disp_op         = '0;
    disp_op.pc      = DispPc;
    disp_op.mop     = DispMicOp;
    disp_op.s1_able = DispSrc1Able;
    disp_op.s1_tag  = DispSrc1Addr;
    disp_op.s2_able = DispSrc2Able;
    disp_op.s2_tag  = DispSrc2Addr;
    disp_op.imm     = DispImm;
    disp_op.rd_able = DispRdAble;
    disp_op.rd_tag  = DispRdAddr;
    disp_op.rob     = DispROBPtr;
    {disp_r1, disp_op.s1_data} = wake_src(DispSrc1Able, DispSrc1Ready,
      DispSrc1Addr, DispSrc1Date, WakeAble, WakeAddr, WakeDate);
    {disp_r2, disp_op.s2_data} = wake_src(DispSrc2Able, DispSrc2Ready,
      DispSrc2Addr, DispSrc2Date, WakeAble, WakeAddr, WakeDate);
  end

  // -------------------------------------------------------------------------
  // Select: oldest (lowest index) entry whose sources are both satisfied,
  // judged on registered state only.
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] ent_rdy;
  logic             sel_hit;
  logic [CNTW-1:0]  sel_idx;
  uop_t             sel_op;
  logic             issue;
  logic             accept;

  always_comb begin
    ent_rdy = '0;
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_op  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_rdy[k] = valid_q[k] &
                   (~ent_q[k].s1_able | rdy1_q[k]) &
                   (~ent_q[k].s2_able | rdy2_q[k]);
      if (ent_rdy[k] && !sel_hit) begin
        sel_hit = 1'b1;
        sel_idx = CNTW'(k);
        sel_op  = ent_q[k];
      end
    end
    issue  = AluReq & sel_hit;
    accept = DispAble & ~IqFull & ~IqFlash;
  end

  // -------------------------------------------------------------------------
  // Next queue state: entries at and above the issued index take the value
  // of their upper neighbour (collapse), then the accepted op is written at
  // the first free slot after the collapse.
  // -------------------------------------------------------------------------
  uop_t             ent_up [DEPTH];
  logic [DEPTH-1:0] rdy1_up;
  logic [DEPTH-1:0] rdy2_up;
  logic [DEPTH-1:0] valid_up;
  uop_t             ent_d  [DEPTH];
  logic [DEPTH-1:0] rdy1_d;
  logic [DEPTH-1:0] rdy2_d;
  logic [DEPTH-1:0] valid_d;
  logic [CNTW-1:0]  wr_idx;
  logic [CNTW-1:0]  count_d;

  always_comb begin
    rdy1_up  = '0;
    rdy2_up  = '0;
    valid_up = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      ent_up[k]   = ent_w[k+1];
      rdy1_up[k]  = rdy1_w[k+1];
      rdy2_up[k]  = rdy2_w[k+1];
      valid_up[k] = valid_q[k+1];
    end
    ent_up[DEPTH-1] = '0;

    wr_idx  = count - CNTW'(issue);
    count_d = count + CNTW'(accept) - CNTW'(issue);

    rdy1_d  = '0;
    rdy2_d  = '0;
    valid_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (issue && (CNTW'(k) >= sel_idx)) begin
        ent_d[k]   = ent_up[k];
        rdy1_d[k]  = rdy1_up[k];
        rdy2_d[k]  = rdy2_up[k];
        valid_d[k] = valid_up[k];
      end else begin
        ent_d[k]   = ent_w[k];
        rdy1_d[k]  = rdy1_w[k];
        rdy2_d[k]  = rdy2_w[k];
        valid_d[k] = valid_q[k];
      end
      if (accept && (CNTW'(k) == wr_idx)) begin
        ent_d[k]   = disp_op;
        rdy1_d[k]  = disp_r1;
        rdy2_d[k]  = disp_r2;
        valid_d[k] = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers. Reset and flush are the same operation.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rest || IqFlash) begin
      ent_q   <= '{default: '0};
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count   <= '0;
      IqFull  <= 1'b0;
      iss_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      count   <= count_d;
      IqFull  <= (count_d == CNTW'(DEPTH));
      // Issue is a single-cycle pulse; a nop is loaded whenever nothing goes.
      iss_q   <= issue ? sel_op : '0;
    end
  end

  // Issue port. Source enables/tags pass through so the ALU bypass mux can
  // still override the captured data.
  assign AluInstPc     = iss_q.pc;
  assign AluMicOperate = iss_q.mop;
  assign AluSrc1Able   = iss_q.s1_able;
  assign AluSrc1Addr   = iss_q.s1_tag;
  assign AluSrc1Date   = iss_q.s1_data;
  assign AluSrc2Able   = iss_q.s2_able;
  assign AluSrc2Addr   = iss_q.s2_tag;
  assign AluSrc2Date   = iss_q.s2_data;
  assign AluImmDate    = iss_q.imm;
  assign AluRdAble     = iss_q.rd_able;
  assign AluRdAddr     = iss_q.rd_tag;
  assign AluROBPtr     = iss_q.rob;

endmodule

// File: tb/tb_iq_int_alu.sv
// ---------------------------------------------------------------------------
// tb_iq_int_alu : self-checking bench for iq_int_alu.
// Reference model: an age-ordered SV queue of ops. Each cycle it drops the
// first ready op (if the ALU asked), applies broadcasts to the rest, and
// appends the accepted dispatch op. Directed scenarios come first, then
// randomized traffic.
// ---------------------------------------------------------------------------
module tb_iq_int_alu;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;
  localparam int MOPW  = 8;
  localparam int W     = 154;

  // ---------------- clock / reset / DUT ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Rest, IqFlash, DispAble;
  logic [31:0]      DispPc;
  logic [MOPW-1:0]  DispMicOp;
  logic             DispSrc1Able, DispSrc1Ready, DispSrc2Able, DispSrc2Ready;
  logic [6:0]       DispSrc1Addr, DispSrc2Addr, DispRdAddr;
  logic [31:0]      DispSrc1Date, DispSrc2Date;
  logic [19:0]      DispImm;
  logic             DispRdAble;
  logic [5:0]       DispROBPtr;
  logic             IqFull;
  logic [4:0]       WakeAble;
  logic [34:0]      WakeAddr;
  logic [159:0]     WakeDate;
  logic             AluReq;
  logic [31:0]      AluInstPc, AluSrc1Date, AluSrc2Date;
  logic [MOPW-1:0]  AluMicOperate;
  logic             AluSrc1Able, AluSrc2Able, AluRdAble;
  logic [6:0]       AluSrc1Addr, AluSrc2Addr, AluRdAddr;
  logic [19:0]      AluImmDate;
  logic [5:0]       AluROBPtr;

  iq_int_alu #(.DEPTH(DEPTH), .CNTW(CNTW), .MOPW(MOPW)) dut (
    .Clk(Clk), .Rest(Rest), .IqFlash(IqFlash), .DispAble(DispAble),
    .DispPc(DispPc), .DispMicOp(DispMicOp),
    .DispSrc1Able(DispSrc1Able), .DispSrc1Addr(DispSrc1Addr),
    .DispSrc1Ready(DispSrc1Ready), .DispSrc1Date(DispSrc1Date),
    .DispSrc2Able(DispSrc2Able), .DispSrc2Addr(DispSrc2Addr),
    .DispSrc2Ready(DispSrc2Ready), .DispSrc2Date(DispSrc2Date),
    .DispImm(DispImm), .DispRdAble(DispRdAble), .DispRdAddr(DispRdAddr),
    .DispROBPtr(DispROBPtr), .IqFull(IqFull),
    .WakeAble(WakeAble), .WakeAddr(WakeAddr), .WakeDate(WakeDate),
    .AluReq(AluReq), .AluInstPc(AluInstPc), .AluMicOperate(AluMicOperate),
    .AluSrc1Able(AluSrc1Able), .AluSrc1Addr(AluSrc1Addr), .AluSrc1Date(AluSrc1Date),
    .AluSrc2Able(AluSrc2Able), .AluSrc2Addr(AluSrc2Addr), .AluSrc2Date(AluSrc2Date),
    .AluImmDate(AluImmDate), .AluRdAble(AluRdAble), .AluRdAddr(AluRdAddr),
    .AluROBPtr(AluROBPtr)
  );

  // ---------------- op record and reference model ----------------
  typedef struct {
    logic [31:0]     pc;
    logic [MOPW-1:0] mop;
    logic            s1a;
    logic [6:0]      s1t;
    logic            s1r;
    logic [31:0]     s1d;
    logic            s2a;
    logic [6:0]      s2t;
    logic            s2r;
    logic [31:0]     s2d;
    logic [19:0]     imm;
    logic            rda;
    logic [6:0]      rdt;
    logic [5:0]      rob;
  } op_t;

  op_t          mq[$];      // model queue, oldest at front
  logic [W-1:0] exp_q[$];   // scoreboard of expected issue-port values
  int           n_chk;
  int           n_pass;

  function automatic logic [W-1:0] pack(input op_t o);
    return {o.pc, o.mop, o.s1a, o.s1t, o.s1d, o.s2a, o.s2t, o.s2d,
            o.imm, o.rda, o.rdt, o.rob};
  endfunction

  function automatic logic [W-1:0] out_bus();
    return {AluInstPc, AluMicOperate, AluSrc1Able, AluSrc1Addr, AluSrc1Date,
            AluSrc2Able, AluSrc2Addr, AluSrc2Date, AluImmDate, AluRdAble,
            AluRdAddr, AluROBPtr};
  endfunction

  function automatic bit op_ready(input op_t o);
    return (!o.s1a || o.s1r) && (!o.s2a || o.s2r);
  endfunction

  // Apply this cycle's broadcasts; first matching slot wins.
  function automatic op_t wake(input op_t o);
    op_t r;
    r = o;
    if (o.s1a && !o.s1r) begin
      for (int i = 0; i < 5; i++) begin
        if (WakeAble[i] && WakeAddr[7*i +: 7] == o.s1t) begin
          r.s1r = 1'b1; r.s1d = WakeDate[32*i +: 32]; break;
        end
      end
    end
    if (o.s2a && !o.s2r) begin
      for (int i = 0; i < 5; i++) begin
        if (WakeAble[i] && WakeAddr[7*i +: 7] == o.s2t) begin
          r.s2r = 1'b1; r.s2d = WakeDate[32*i +: 32]; break;
        end
      end
    end
    return r;
  endfunction

  function automatic op_t disp_now();
    op_t o;
    o.pc = DispPc; o.mop = DispMicOp;
    o.s1a = DispSrc1Able; o.s1t = DispSrc1Addr; o.s1r = DispSrc1Ready; o.s1d = DispSrc1Date;
    o.s2a = DispSrc2Able; o.s2t = DispSrc2Addr; o.s2r = DispSrc2Ready; o.s2d = DispSrc2Date;
    o.imm = DispImm; o.rda = DispRdAble; o.rdt = DispRdAddr; o.rob = DispROBPtr;
    return o;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step(output logic [W-1:0] exp_iss, output logic exp_full);
    bit full_now;
    int pick;
    exp_iss = '0;
    if (!Rest || IqFlash) begin
      mq.delete();
      exp_full = 1'b0;
      return;
    end
    full_now = (mq.size() == DEPTH);
    pick = -1;
    if (AluReq) begin
      foreach (mq[i]) if (pick < 0 && op_ready(mq[i])) pick = i;
    end
    if (pick >= 0) begin
      exp_iss = pack(mq[pick]);
      mq.delete(pick);
    end
    foreach (mq[i]) mq[i] = wake(mq[i]);
    if (DispAble && !full_now) mq.push_back(wake(disp_now()));
    exp_full = (mq.size() == DEPTH);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    DispAble = 1'b0; DispPc = '0; DispMicOp = '0;
    DispSrc1Able = 1'b0; DispSrc1Addr = '0; DispSrc1Ready = 1'b0; DispSrc1Date = '0;
    DispSrc2Able = 1'b0; DispSrc2Addr = '0; DispSrc2Ready = 1'b0; DispSrc2Date = '0;
    DispImm = '0; DispRdAble = 1'b0; DispRdAddr = '0; DispROBPtr = '0;
    WakeAble = '0; WakeAddr = '0; WakeDate = '0; IqFlash = 1'b0;
  endtask

  task automatic set_disp(input op_t o);
    DispAble = 1'b1; DispPc = o.pc; DispMicOp = o.mop;
    DispSrc1Able = o.s1a; DispSrc1Addr = o.s1t; DispSrc1Ready = o.s1r; DispSrc1Date = o.s1d;
    DispSrc2Able = o.s2a; DispSrc2Addr = o.s2t; DispSrc2Ready = o.s2r; DispSrc2Date = o.s2d;
    DispImm = o.imm; DispRdAble = o.rda; DispRdAddr = o.rdt; DispROBPtr = o.rob;
  endtask

  task automatic set_wake(input int slot, input logic [6:0] tag, input logic [31:0] data);
    WakeAble[slot] = 1'b1;
    WakeAddr[7*slot +: 7] = tag;
    WakeDate[32*slot +: 32] = data;
  endtask

  function automatic op_t mk_op(input logic [31:0] pc, input logic [MOPW-1:0] mop,
                                input logic s1a, input logic [6:0] s1t, input logic s1r,
                                input logic [31:0] s1d,
                                input logic s2a, input logic [6:0] s2t, input logic s2r,
                                input logic [31:0] s2d,
                                input logic [19:0] imm, input logic [6:0] rdt,
                                input logic [5:0] rob);
    op_t o;
    o.pc = pc; o.mop = mop;
    o.s1a = s1a; o.s1t = s1t; o.s1r = s1r; o.s1d = s1d;
    o.s2a = s2a; o.s2t = s2t; o.s2r = s2r; o.s2d = s2d;
    o.imm = imm; o.rda = 1'b1; o.rdt = rdt; o.rob = rob;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.pc  = $urandom;
    o.mop = MOPW'($urandom_range(1, 255));
    o.s1a = 1'($urandom_range(0, 1));
    o.s1t = 7'($urandom_range(0, 7));
    o.s1r = 1'($urandom_range(0, 1));
    o.s1d = o.s1a ? $urandom : 32'd0;
    o.s2a = 1'($urandom_range(0, 1));
    o.s2t = 7'($urandom_range(0, 7));
    o.s2r = 1'($urandom_range(0, 1));
    o.s2d = o.s2a ? $urandom : 32'd0;
    o.imm = 20'($urandom);
    o.rda = 1'($urandom_range(0, 1));
    o.rdt = 7'($urandom);
    o.rob = 6'($urandom);
    return o;
  endfunction

  // One clock: model predicts, DUT is sampled 1 time unit after the edge.
  task automatic cycle(input string tag);
    logic [W-1:0] e;
    logic         f;
    model_step(e, f);
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    check({tag, "/issue"}, out_bus(), exp_q.pop_front());
    check({tag, "/full"}, W'(IqFull), W'(f));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_chk = 0; n_pass = 0;
    Rest = 1'b0; AluReq = 1'b0;
    idle();
    cycle("rst0");
    cycle("rst1");
    check("rst_count", W'(dut.count), '0);
    Rest = 1'b1;

    // Ready addi: on the issue port two posedges after dispatch, then nop.
    AluReq = 1'b1; idle();
    set_disp(mk_op(32'h100, 8'h01, 1'b1, 7'h05, 1'b1, 32'd5, 1'b0, 7'h00, 1'b0, 32'd0,
                   20'd3, 7'h20, 6'd1));
    cycle("t1_disp");
    check("t1_no_same_cycle", W'(AluMicOperate), '0);
    idle(); cycle("t1_iss");
    check("t1_src1", W'(AluSrc1Date), W'(32'd5));
    check("t1_imm", W'(AluImmDate), W'(20'd3));
    idle(); cycle("t1_after");
    check("t1_nop_mop", W'(AluMicOperate), '0);
    check("t1_nop_rd", W'(AluRdAble), '0);

    // Younger ready op bypasses an older waiting one; Alu2 wake releases it.
    idle();
    set_disp(mk_op(32'h200, 8'h02, 1'b1, 7'h12, 1'b0, 32'd0, 1'b0, 7'h00, 1'b0, 32'd0,
                   20'd0, 7'h21, 6'd2));
    cycle("t2_a");
    idle();
    set_disp(mk_op(32'h204, 8'h03, 1'b1, 7'h05, 1'b1, 32'h7, 1'b1, 7'h06, 1'b1, 32'h8,
                   20'd1, 7'h22, 6'd3));
    cycle("t2_b");
    idle(); cycle("t2_b_iss");
    check("t2_b_first", W'(AluInstPc), W'(32'h204));
    idle(); set_wake(2, 7'h12, 32'hDEAD); cycle("t2_wake");
    check("t2_a_waits", W'(AluMicOperate), '0);
    idle(); cycle("t2_a_iss");
    check("t2_a_pc", W'(AluInstPc), W'(32'h200));
    check("t2_a_data", W'(AluSrc1Date), W'(32'hDEAD));

    // Fill to DEPTH with AluReq low; a ninth dispatch is ignored.
    AluReq = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      set_disp(mk_op(32'h1000 + 32'(4*i), 8'h10 + 8'(i), 1'b1, 7'(i), 1'b1, 32'(3*i),
                     1'b0, 7'h00, 1'b0, 32'd0, 20'(i), 7'(40 + i), 6'(i)));
      cycle("t3_fill");
    end
    check("t3_full", W'(IqFull), W'(1'b1));
    idle();
    set_disp(mk_op(32'hBAD0, 8'h7F, 1'b0, 7'h00, 1'b1, 32'd0, 1'b0, 7'h00, 1'b0, 32'd0,
                   20'd9, 7'h09, 6'd9));
    cycle("t3_ninth");
    check("t3_count8", W'(dut.count), W'(4'd8));

    // Full, AluReq and dispatch together: one issues, the dispatch is dropped.
    AluReq = 1'b1; idle();
    set_disp(mk_op(32'hBEEF, 8'h7E, 1'b0, 7'h00, 1'b1, 32'd0, 1'b0, 7'h00, 1'b0, 32'd0,
                   20'd8, 7'h08, 6'd8));
    cycle("t4_iss_disp");
    check("t4_pc0", W'(AluInstPc), W'(32'h1000));
    check("t4_count7", W'(dut.count), W'(4'd7));
    check("t4_not_full", W'(IqFull), '0);
    for (int i = 1; i < DEPTH; i++) begin
      idle(); cycle("t3_drain");
      check("t3_order", W'(AluInstPc), W'(32'h1000 + 32'(4*i)));
    end
    idle(); cycle("t3_empty");

    // Alu and Mul slots broadcast the same tag: the lower slot (Alu) wins.
    AluReq = 1'b0; idle();
    set_disp(mk_op(32'h300, 8'h05, 1'b1, 7'h33, 1'b0, 32'd0, 1'b0, 7'h00, 1'b0, 32'd0,
                   20'd0, 7'h23, 6'd4));
    cycle("t5_disp");
    idle(); set_wake(0, 7'h33, 32'd1); set_wake(3, 7'h33, 32'd2); cycle("t5_wake");
    AluReq = 1'b1; idle(); cycle("t5_iss");
    check("t5_lowest_slot", W'(AluSrc1Date), W'(32'd1));

    // Flush with four entries and a pending wake.
    AluReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      set_disp(mk_op(32'h400 + 32'(4*i), 8'h20, 1'b1, 7'h44, 1'(i != 2), 32'd0,
                     1'b0, 7'h00, 1'b0, 32'd0, 20'd0, 7'h24, 6'(i)));
      cycle("t6_fill");
    end
    idle(); set_wake(1, 7'h44, 32'h55); IqFlash = 1'b1; AluReq = 1'b1;
    cycle("t6_flush");
    check("t6_count0", W'(dut.count), '0);
    AluReq = 1'b0; idle();
    set_disp(mk_op(32'h500, 8'h30, 1'b0, 7'h00, 1'b1, 32'd0, 1'b0, 7'h00, 1'b0, 32'd0,
                   20'd5, 7'h25, 6'd5));
    cycle("t6_redisp");
    check("t6_idx0", W'(dut.valid_q), W'(8'b0000_0001));
    AluReq = 1'b1; idle(); cycle("t6_iss");
    check("t6_pc", W'(AluInstPc), W'(32'h500));

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      idle();
      AluReq  = ($urandom_range(0, 3) != 0);
      Rest    = ($urandom_range(0, 199) != 0);
      IqFlash = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0) set_disp(rand_op());
      for (int s = 0; s < 5; s++) begin
        if ($urandom_range(0, 3) == 0) set_wake(s, 7'($urandom_range(0, 7)), $urandom);
      end
      cycle("rand");
    end

    Rest = 1'b1; AluReq = 1'b1;
    for (int c = 0; c < 12; c++) begin
      idle(); cycle("drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iq_int_alu.md
Name: iq_int_alu

Overview:
- Integer issue queue feeding the ALU execution unit.
- Accepts renamed micro-ops from dispatch and holds them until both sources are ready.
- Sources become ready at dispatch or by capturing values from writeback/bypass broadcasts.
- Issues the oldest ready op to the ALU each cycle the ALU requests. Sits between rename/dispatch and the ALU.

Parameters:
DEPTH, 8, number of queue entries
CNTW, 4, width of occupancy count (log2(DEPTH)+1)

Ports:
Clk  in  1  clock
Rest  in  1  synchronous active-low reset
IqFlash  in  1  ctrl flush; clears queue and issue register
DispAble  in  1  dispatch valid
DispPc  in  32  instruction PC
DispMicOp  in  `MicOperateCode  micro-op code
DispSrc1Able / DispSrc2Able  in  1  source N used
DispSrc1Addr / DispSrc2Addr  in  7  physical tag of source N
DispSrc1Ready / DispSrc2Ready  in  1  source N value already valid
DispSrc1Date / DispSrc2Date  in  32  source N value (meaningful when Ready)
DispImm  in  20  immediate
DispRdAble  in  1  has destination
DispRdAddr  in  7  destination physical tag
DispROBPtr  in  6  ROB index
IqFull  out  1  queue full; dispatch must not assert DispAble
WakeAble  in  5  broadcast valids {Csr,Mul,Alu2,Bru,Alu}, bit0 = Alu
WakeAddr  in  35  7-bit tag per broadcast, slot i at [7i+6:7i]
WakeDate  in  160  32-bit value per broadcast, slot i at [32i+31:32i]
AluReq  in  1  ALU can accept an op this cycle
AluInstPc, AluMicOperate, AluSrc1Able, AluSrc1Addr, AluSrc1Date, AluSrc2Able, AluSrc2Addr, AluSrc2Date, AluImmDate, AluRdAble, AluRdAddr, AluROBPtr  out  32/`MicOperateCode/1/7/32/1/7/32/20/1/7/6  issued op (registered)

Behaviour:
- Reset: synchronous on Rest=0. All entries invalid, count=0, IqFull=0. Every issue output is 0; MicOp 0 is a non-committing nop at the ALU.
- Entry fields: valid, every dispatch field, plus per-source ready bit and data. Source N is satisfied when !SrcNAble or SrcNReady. An entry is ready when valid and both sources are satisfied.
- Ordering: collapsing queue; index 0 is oldest and valid entries are contiguous from 0.
- Wakeup, each cycle, for every valid entry and every source with Able=1 and Ready=0:
  - If WakeAble[i] and WakeAddr slot i equals the source tag, set Ready and capture WakeDate slot i.
  - If several slots match, the lowest i wins.
  - A woken entry becomes eligible the following cycle.
- Select: when AluReq=1, pick the lowest-index ready entry. At posedge, load it into the issue register and remove it; entries above it shift down by one.
- No issue: when AluReq=0 or no entry is ready, the issue register loads all-zero (nop). Every issue is a one-cycle pulse; the register never holds an op for two cycles.
- Issued SrcNAble/SrcNAddr are passed through unchanged so the ALU bypass mux still applies.
- Dispatch:
  - Accepted when DispAble=1, IqFull=0, IqFlash=0.
  - Written at index (count − issued_this_cycle), i.e. after the collapse.
  - The same-cycle wakeup comparison also applies to the incoming op's non-ready sources.
  - A newly dispatched op is never issued in the cycle it arrives.
- IqFull = (count == DEPTH), registered from count. Issue and dispatch in the same cycle while full: dispatch is not accepted. DispAble while full is ignored.
- count next = count + accepted − issued; never exceeds DEPTH or goes below 0.
- Flush: IqFlash=1 has priority over dispatch, issue and wakeup. Next cycle all entries are invalid, count=0, and the issue register is nop.
- Reset asserted mid-operation behaves exactly as flush.

Test Plan:
- Reset, then dispatch addi (Src1Ready=1, Src1Date=5, Imm=3) with AluReq=1: issue outputs carry that op two posedges after dispatch. The cycle after the pulse, MicOp=0 and RdAble=0.
- Dispatch op A with src1 tag 0x12 not ready, then op B fully ready: B issues first. Then assert WakeAble=5'b00100 with Alu2 tag 0x12 and data 0xDEAD: A issues one cycle later with AluSrc1Date=0xDEAD.
- Hold AluReq=0 and dispatch 8 ready ops: IqFull=1, a 9th DispAble is ignored. Raise AluReq: ops issue in dispatch order, one per cycle, and IqFull drops after the first issue.
- Queue full with AluReq=1, dispatch asserted the same cycle: one op issues, the dispatched op is dropped, count=7.
- Two wake slots (Alu and Mul) broadcast the same tag with values 1 and 2: the entry captures 1.
- 4 valid entries plus a pending wake, assert IqFlash: next cycle count=0, IqFull=0, issue outputs all zero; a subsequent dispatch lands at index 0.
